// File: rtl/gbc_hdma_engine.sv
// Game Boy Color VRAM DMA engine (GDMA and HBlank DMA) moving 16-byte blocks
// from a pipelined source read port to a write-only VRAM port.
module gbc_hdma_engine #(
  parameter int SrcAddrWidth  = 16,
  parameter int VramAddrWidth = 13
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2:0]               REG_SEL,
  input  logic                     REG_WE,
  input  logic [7:0]               REG_DI,
  output logic [7:0]               REG_DO,
  input  logic                     HBLANK,
  input  logic                     LCD_ON,
  output logic                     CPU_HOLD,
  output logic                     SRC_STB,
  output logic [SrcAddrWidth-1:0]  SRC_ADDR,
  input  logic [7:0]               SRC_DAT,
  input  logic                     SRC_ACK,
  input  logic                     SRC_STALL,
  output logic                     VRAM_STB,
  output logic [VramAddrWidth-1:0] VRAM_ADDR,
  output logic [7:0]               VRAM_DAT,
  input  logic                     VRAM_ACK,
  input  logic                     VRAM_STALL
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StArmed    = 3'd1;
  localparam logic [2:0] StRead     = 3'd2;
  localparam logic [2:0] StWrite    = 3'd3;
  localparam logic [2:0] StBlockEnd = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] srcAddr_q, srcAddr_d;
  logic [12:0] dstAddr_q, dstAddr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  byteCnt_q, byteCnt_d;
  logic [6:0]  remaining_q, remaining_d;
  logic        hdma_q, hdma_d;
  logic        cancelPend_q, cancelPend_d;
  logic        cancelled_q, cancelled_d;
  logic        srcStb_q, srcStb_d;
  logic        vramStb_q, vramStb_d;
  logic        hblank_q;
  logic        hblankEdge;
  logic        wr55;

  assign hblankEdge = HBLANK & ~hblank_q & LCD_ON;
  assign wr55       = REG_WE && (REG_SEL == 3'd5);

  // The address counters double as FF51..FF54; they keep advancing across blocks.
  always_comb begin
    state_d      = state_q;
    srcAddr_d    = srcAddr_q;
    dstAddr_d    = dstAddr_q;
    data_d       = data_q;
    byteCnt_d    = byteCnt_q;
    remaining_d  = remaining_q;
    hdma_d       = hdma_q;
    cancelPend_d = cancelPend_q;
    cancelled_d  = cancelled_q;
    srcStb_d     = srcStb_q;
    vramStb_d    = vramStb_q;
    case (state_q)
      StIdle: begin
        if (REG_WE) begin
          case (REG_SEL)
            3'd1:    srcAddr_d[15:8] = REG_DI;
            3'd2:    srcAddr_d[7:0]  = {REG_DI[7:4], 4'h0};
            3'd3:    dstAddr_d[12:8] = REG_DI[4:0];
            3'd4:    dstAddr_d[7:0]  = {REG_DI[7:4], 4'h0};
            default: ;
          endcase
        end
      end
      StArmed: begin
        if (hblankEdge) begin
          state_d  = StRead;
          srcStb_d = 1'b1;
        end
      end
      StRead: begin
        if (srcStb_q) begin
          if (!SRC_STALL) srcStb_d = 1'b0;
        end else if (SRC_ACK) begin
          data_d    = SRC_DAT;
          state_d   = StWrite;
          vramStb_d = 1'b1;
        end
      end
      StWrite: begin
        if (vramStb_q) begin
          if (!VRAM_STALL) vramStb_d = 1'b0;
        end else if (VRAM_ACK) begin
          srcAddr_d = srcAddr_q + 16'd1;
          dstAddr_d = dstAddr_q + 13'd1;
          byteCnt_d = byteCnt_q + 4'd1;
          if (byteCnt_q == 4'hF) begin
            state_d = StBlockEnd;
          end else begin
            state_d  = StRead;
            srcStb_d = 1'b1;
          end
        end
      end
      StBlockEnd: begin
        cancelPend_d = 1'b0;
        if (remaining_q == 7'd0) begin
          state_d     = StIdle;
          cancelled_d = 1'b0;
        end else begin
          remaining_d = remaining_q - 7'd1;
          if (cancelPend_q) begin
            state_d     = StIdle;
            cancelled_d = 1'b1;
          end else if (hdma_q) begin
            state_d = StArmed;
          end else begin
            state_d  = StRead;
            srcStb_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // An FF55 write is judged against the post-block-end state.
    if (wr55) begin
      if (state_d == StIdle) begin
        remaining_d  = REG_DI[6:0];
        hdma_d       = REG_DI[7];
        cancelled_d  = 1'b0;
        cancelPend_d = 1'b0;
        byteCnt_d    = 4'd0;
        if (REG_DI[7]) begin
          state_d = StArmed;
        end else begin
          state_d  = StRead;
          srcStb_d = 1'b1;
        end
      end else if (hdma_q) begin
        if (REG_DI[7]) begin
          remaining_d  = REG_DI[6:0];
          cancelPend_d = 1'b0;
        end else if (state_d == StArmed) begin
          state_d     = StIdle;
          cancelled_d = 1'b1;
        end else begin
          cancelPend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      srcAddr_q    <= '0;
      dstAddr_q    <= '0;
      data_q       <= '0;
      byteCnt_q    <= '0;
      remaining_q  <= '0;
      hdma_q       <= 1'b0;
      cancelPend_q <= 1'b0;
      cancelled_q  <= 1'b0;
      srcStb_q     <= 1'b0;
      vramStb_q    <= 1'b0;
      hblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      srcAddr_q    <= srcAddr_d;
      dstAddr_q    <= dstAddr_d;
      data_q       <= data_d;
      byteCnt_q    <= byteCnt_d;
      remaining_q  <= remaining_d;
      hdma_q       <= hdma_d;
      cancelPend_q <= cancelPend_d;
      cancelled_q  <= cancelled_d;
      srcStb_q     <= srcStb_d;
      vramStb_q    <= vramStb_d;
      hblank_q     <= HBLANK;
    end
  end

  always_comb begin
    REG_DO = 8'hFF;
    if (REG_SEL == 3'd5) begin
      if (state_q != StIdle)  REG_DO = {1'b0, remaining_q};
      else if (cancelled_q)   REG_DO = {1'b1, remaining_q};
    end
  end

  assign CPU_HOLD  = (state_q == StRead) || (state_q == StWrite) || (state_q == StBlockEnd);
  assign SRC_STB   = srcStb_q;
  assign SRC_ADDR  = SrcAddrWidth'(srcAddr_q);
  assign VRAM_STB  = vramStb_q;
  assign VRAM_ADDR = VramAddrWidth'(dstAddr_q);
  assign VRAM_DAT  = data_q;

endmodule

// File: tb/tb_gbc_hdma_engine.sv
// Bench for gbc_hdma_engine: randomized source memory and bus stalls, with
// expected transfers computed from the register formulas and byte ordering.
module tb_gbc_hdma_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  REG_SEL = 3'd5;
  logic        REG_WE = 1'b0;
  logic [7:0]  REG_DI = 8'h00;
  logic [7:0]  REG_DO;
  logic        HBLANK = 1'b0;
  logic        LCD_ON = 1'b0;
  logic        CPU_HOLD;
  logic        SRC_STB;
  logic [15:0] SRC_ADDR;
  logic [7:0]  SRC_DAT = 8'h00;
  logic        SRC_ACK = 1'b0;
  logic        SRC_STALL = 1'b0;
  logic        VRAM_STB;
  logic [12:0] VRAM_ADDR;
  logic [7:0]  VRAM_DAT;
  logic        VRAM_ACK = 1'b0;
  logic        VRAM_STALL = 1'b0;

  gbc_hdma_engine #(.SrcAddrWidth(16), .VramAddrWidth(13)) dut (
    .CLK(CLK), .RST(RST), .REG_SEL(REG_SEL), .REG_WE(REG_WE), .REG_DI(REG_DI),
    .REG_DO(REG_DO), .HBLANK(HBLANK), .LCD_ON(LCD_ON), .CPU_HOLD(CPU_HOLD),
    .SRC_STB(SRC_STB), .SRC_ADDR(SRC_ADDR), .SRC_DAT(SRC_DAT), .SRC_ACK(SRC_ACK),
    .SRC_STALL(SRC_STALL), .VRAM_STB(VRAM_STB), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_DAT(VRAM_DAT), .VRAM_ACK(VRAM_ACK), .VRAM_STALL(VRAM_STALL)
  );

  always #5 CLK = ~CLK;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  logic [7:0]  srcMem [65536];
  logic [15:0] srcLog [$];
  logic [12:0] vLogA [$];
  logic [7:0]  vLogD [$];
  logic [15:0] expSrcBase;
  logic [12:0] expDstBase;
  int          forceSrcStall = 0;
  int          forceVramStall = 0;
  bit          randomStall = 1'b1;

  // responder state
  bit          sPending = 0, vPending = 0;
  int          sDelay = 0, vDelay = 0;
  logic [15:0] sPendAddr = '0;
  bit          sPrevStb = 0, sPrevStall = 0, vPrevStb = 0, vPrevStall = 0;
  logic [15:0] sPrevAddr = '0;
  logic [12:0] vPrevAddr = '0;
  logic [7:0]  vPrevDat = '0;

  // main-flow scratch
  logic [7:0]  rd;
  logic [7:0]  r51, r52, r53, r54;
  logic [15:0] firstSrc;
  logic [12:0] firstDst;
  bit          timedOut;
  int          gaps;
  int          nBlocks;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Source port slave: random stalls, 1..3 cycle ack latency, data from srcMem.
  initial begin : srcResponder
    forever begin
      @(negedge CLK);
      if (RST) begin
        sPending = 0; SRC_ACK = 1'b0; SRC_STALL = 1'b0; sPrevStb = 0; sPrevStall = 0;
      end else begin
        if (sPrevStb && sPrevStall) begin
          checkOutput("src_stall_stb", SRC_STB, 1);
          checkOutput("src_stall_addr", SRC_ADDR, sPrevAddr);
        end
        if (SRC_STB || VRAM_STB) checkOutput("exclusive_stb", SRC_STB & VRAM_STB, 0);
        SRC_ACK = 1'b0;
        if (sPending) begin
          if (sDelay == 1) begin
            SRC_ACK = 1'b1; SRC_DAT = srcMem[sPendAddr]; sPending = 0;
          end else sDelay--;
        end
        if (SRC_STB) begin
          if (forceSrcStall > 0) begin
            SRC_STALL = 1'b1; forceSrcStall--;
          end else SRC_STALL = randomStall && ($urandom_range(0, 3) == 0);
          if (!SRC_STALL) begin
            sPending = 1; sPendAddr = SRC_ADDR; sDelay = $urandom_range(1, 3);
            srcLog.push_back(SRC_ADDR);
          end
        end else SRC_STALL = randomStall && ($urandom_range(0, 1) == 0);
        sPrevStb = SRC_STB; sPrevStall = SRC_STALL; sPrevAddr = SRC_ADDR;
      end
    end
  end

  // VRAM port slave: records every accepted write.
  initial begin : vramResponder
    forever begin
      @(negedge CLK);
      if (RST) begin
        vPending = 0; VRAM_ACK = 1'b0; VRAM_STALL = 1'b0; vPrevStb = 0; vPrevStall = 0;
      end else begin
        if (vPrevStb && vPrevStall) begin
          checkOutput("vram_stall_stb", VRAM_STB, 1);
          checkOutput("vram_stall_addr", {VRAM_ADDR, VRAM_DAT}, {vPrevAddr, vPrevDat});
        end
        VRAM_ACK = 1'b0;
        if (vPending) begin
          if (vDelay == 1) begin
            VRAM_ACK = 1'b1; vPending = 0;
          end else vDelay--;
        end
        if (VRAM_STB) begin
          if (forceVramStall > 0) begin
            VRAM_STALL = 1'b1; forceVramStall--;
          end else VRAM_STALL = randomStall && ($urandom_range(0, 3) == 0);
          if (!VRAM_STALL) begin
            vPending = 1; vDelay = $urandom_range(1, 3);
            vLogA.push_back(VRAM_ADDR); vLogD.push_back(VRAM_DAT);
          end
        end else VRAM_STALL = randomStall && ($urandom_range(0, 1) == 0);
        vPrevStb = VRAM_STB; vPrevStall = VRAM_STALL; vPrevAddr = VRAM_ADDR; vPrevDat = VRAM_DAT;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic regWrite(input logic [2:0] sel, input logic [7:0] d);
    @(negedge CLK);
    REG_SEL = sel; REG_DI = d; REG_WE = 1'b1;
    @(negedge CLK);
    REG_WE = 1'b0; REG_SEL = 3'd5;
  endtask

  task automatic readReg(input logic [2:0] sel, output logic [7:0] v);
    REG_SEL = sel;
    #1 v = REG_DO;
    REG_SEL = 3'd5;
  endtask

  task automatic applyStimulus(input logic [7:0] a51, a52, a53, a54, a55);
    regWrite(3'd1, a51);
    regWrite(3'd2, a52);
    regWrite(3'd3, a53);
    regWrite(3'd4, a54);
    expSrcBase = {a51, a52 & 8'hF0};
    expDstBase = {a53[4:0], a54 & 8'hF0};
    srcLog.delete(); vLogA.delete(); vLogD.delete();
    regWrite(3'd5, a55);
  endtask

  // Byte j of a transfer reads base+j (wrapping) and writes that byte to dst+j.
  task automatic checkBlock(input int first, input int n, input string tag);
    logic [15:0] s;
    logic [12:0] d;
    checkOutput({tag, "_rd_count"}, 64'(srcLog.size()), 64'(first + n));
    checkOutput({tag, "_wr_count"}, 64'(vLogA.size()), 64'(first + n));
    for (int j = first; j < first + n; j++) begin
      if (j < srcLog.size() && j < vLogA.size()) begin
        s = 16'(int'(expSrcBase) + j);
        d = 13'(int'(expDstBase) + j);
        checkOutput($sformatf("%s_byte%0d", tag, j),
                    {srcLog[j], 3'b0, vLogA[j], vLogD[j]}, {s, 3'b0, d, srcMem[s]});
      end
    end
  endtask

  task automatic waitGdmaDone(input int bound, output int holdGaps, output bit expired);
    holdGaps = 0;
    expired = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(negedge CLK);
      #1;
      if (REG_DO == 8'hFF) begin
        expired = 1'b0;
        break;
      end
      if (!CPU_HOLD) holdGaps++;
    end
  endtask

  task automatic waitHold(input logic level, input int bound, output bit expired);
    expired = 1'b1;
    for (int c = 0; c < bound; c++) begin
      @(negedge CLK);
      #1;
      if (CPU_HOLD == level) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic hblankBlock(output bit expired);
    bit e1, e2;
    @(negedge CLK);
    HBLANK = 1'b1;
    waitHold(1'b1, 50, e1);
    waitHold(1'b0, 3000, e2);
    repeat (5) @(negedge CLK);
    HBLANK = 1'b0;
    repeat (3) @(negedge CLK);
    expired = e1 | e2;
  endtask

  task automatic hblankPulseOnly();
    @(negedge CLK);
    HBLANK = 1'b1;
    repeat (6) @(negedge CLK);
    HBLANK = 1'b0;
    repeat (20) @(negedge CLK);
  endtask

  initial begin : stimulus
    for (int i = 0; i < 65536; i++) srcMem[i] = 8'($urandom);

    // reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rst_src_stb", SRC_STB, 0);
    checkOutput("rst_vram_stb", VRAM_STB, 0);
    checkOutput("rst_cpu_hold", CPU_HOLD, 0);
    checkOutput("rst_addrs", {SRC_ADDR, VRAM_ADDR, VRAM_DAT}, 0);
    RST = 1'b0;
    @(negedge CLK);
    readReg(3'd5, rd); checkOutput("rst_ff55", rd, 8'hFF);
    readReg(3'd1, rd); checkOutput("rst_ff51", rd, 8'hFF);

    // basic two-block GDMA
    applyStimulus(8'hC0, 8'h00, 8'h80, 8'h00, 8'h01);
    waitGdmaDone(5000, gaps, timedOut);
    checkOutput("gdma_timeout", timedOut, 0);
    checkOutput("gdma_hold_gaps", gaps, 0);
    checkBlock(0, 32, "gdma_basic");
    readReg(3'd5, rd); checkOutput("gdma_ff55_done", rd, 8'hFF);
    checkOutput("gdma_hold_idle", CPU_HOLD, 0);

    // low nibbles and upper destination bits are ignored
    applyStimulus(8'($urandom), 8'h3F, 8'hE1, 8'hFF, 8'h00);
    waitGdmaDone(3000, gaps, timedOut);
    checkOutput("mask_timeout", timedOut, 0);
    firstSrc = (srcLog.size() > 0) ? srcLog[0] : 16'hxxxx;
    firstDst = (vLogA.size() > 0) ? vLogA[0] : 13'hxxxx;
    checkOutput("mask_src_lo", firstSrc[7:0], 8'h30);
    checkOutput("mask_dst", firstDst, 13'h01F0);
    checkBlock(0, 16, "mask");

    // both address counters wrap around their tops
    applyStimulus(8'hFF, 8'hF5, 8'h1F, 8'hF7, 8'h01);
    waitGdmaDone(5000, gaps, timedOut);
    checkOutput("wrap_timeout", timedOut, 0);
    checkBlock(0, 32, "wrap");

    // random GDMA transfers
    for (int t = 0; t < 3; t++) begin
      r51 = 8'($urandom); r52 = 8'($urandom); r53 = 8'($urandom); r54 = 8'($urandom);
      nBlocks = $urandom_range(1, 3);
      applyStimulus(r51, r52, r53, r54, 8'(nBlocks - 1));
      waitGdmaDone(8000, gaps, timedOut);
      checkOutput("rand_timeout", timedOut, 0);
      checkOutput("rand_hold_gaps", gaps, 0);
      checkBlock(0, 16 * nBlocks, $sformatf("rand%0d", t));
    end

    // three-cycle stalls on each port
    randomStall = 1'b0;
    forceSrcStall = 3;
    forceVramStall = 3;
    applyStimulus(8'h40, 8'h10, 8'h05, 8'h20, 8'h00);
    waitGdmaDone(3000, gaps, timedOut);
    checkOutput("stall_timeout", timedOut, 0);
    checkOutput("stall_src_used", forceSrcStall, 0);
    checkOutput("stall_vram_used", forceVramStall, 0);
    checkBlock(0, 16, "stall");
    randomStall = 1'b1;

    // HDMA: edges ignored with LCD off, then one block per edge
    LCD_ON = 1'b0;
    applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h82);
    readReg(3'd5, rd); checkOutput("hdma_armed_ff55", rd, 8'h02);
    checkOutput("hdma_armed_hold", CPU_HOLD, 0);
    hblankPulseOnly();
    checkOutput("hdma_lcd_off_rd", srcLog.size(), 0);
    LCD_ON = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("hdma_no_edge_rd", srcLog.size(), 0);
    for (int b = 0; b < 3; b++) begin
      hblankBlock(timedOut);
      checkOutput("hdma_block_timeout", timedOut, 0);
      checkBlock(16 * b, 16, $sformatf("hdma_blk%0d", b));
      readReg(3'd5, rd);
      checkOutput("hdma_ff55", rd, (b == 2) ? 8'hFF : 8'(1 - b));
      checkOutput("hdma_hold_between", CPU_HOLD, 0);
      repeat (20) @(negedge CLK);
      checkOutput("hdma_quiet_between", vLogA.size(), 16 * (b + 1));
    end

    // cancel while armed
    applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h82);
    hblankBlock(timedOut);
    checkOutput("cancel_block_timeout", timedOut, 0);
    regWrite(3'd5, 8'h00);
    readReg(3'd5, rd); checkOutput("cancel_armed_ff55", rd, 8'h81);
    hblankPulseOnly();
    checkOutput("cancel_armed_quiet", vLogA.size(), 16);
    readReg(3'd5, rd); checkOutput("cancel_armed_ff55_after", rd, 8'h81);

    // cancel mid-block lets the block finish
    applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h81);
    @(negedge CLK);
    HBLANK = 1'b1;
    for (int c = 0; c < 2000 && vLogA.size() < 4; c++) @(negedge CLK);
    regWrite(3'd5, 8'h00);
    waitHold(1'b0, 3000, timedOut);
    checkOutput("cancel_mid_timeout", timedOut, 0);
    HBLANK = 1'b0;
    repeat (3) @(negedge CLK);
    checkBlock(0, 16, "cancel_mid");
    readReg(3'd5, rd); checkOutput("cancel_mid_ff55", rd, 8'h80);
    hblankPulseOnly();
    checkOutput("cancel_mid_quiet", vLogA.size(), 16);

    // re-arming FF55 with bit7 set reloads the remaining count
    applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h80);
    regWrite(3'd5, 8'h81);
    readReg(3'd5, rd); checkOutput("reload_ff55", rd, 8'h01);
    hblankBlock(timedOut);
    checkOutput("reload_blk0_timeout", timedOut, 0);
    hblankBlock(timedOut);
    checkOutput("reload_blk1_timeout", timedOut, 0);
    checkBlock(0, 32, "reload");
    readReg(3'd5, rd); checkOutput("reload_ff55_done", rd, 8'hFF);

    // reset in the middle of a GDMA
    applyStimulus(8'hC0, 8'h00, 8'h80, 8'h00, 8'h01);
    for (int c = 0; c < 2000 && vLogA.size() < 5; c++) @(negedge CLK);
    checkOutput("midrst_reached_byte5", vLogA.size() >= 5, 1);
    RST = 1'b1;
    #1;
    checkOutput("midrst_src_stb", SRC_STB, 0);
    checkOutput("midrst_vram_stb", VRAM_STB, 0);
    checkOutput("midrst_hold", CPU_HOLD, 0);
    checkOutput("midrst_addrs", {SRC_ADDR, VRAM_ADDR}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    readReg(3'd5, rd); checkOutput("midrst_ff55", rd, 8'hFF);
    repeat (10) @(negedge CLK);
    checkOutput("midrst_hold_after", CPU_HOLD, 0);

    // engine recovers cleanly after reset
    applyStimulus(8'h12, 8'h34, 8'h0A, 8'hB0, 8'h00);
    waitGdmaDone(3000, gaps, timedOut);
    checkOutput("post_rst_timeout", timedOut, 0);
    checkBlock(0, 16, "post_rst");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gbc_hdma_engine.md
GBC_HDMA_ENGINE -- requirements
Module: gbc_hdma_engine

Interface
REQ-001 SHALL have parameter SrcAddrWidth, default 16: source bus byte-address width.
REQ-002 SHALL have parameter VramAddrWidth, default 13: VRAM byte-address width within the selected bank.
REQ-003 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REG_SEL  in  3  register select; 1..5 = FF51..FF55, other values unused.
REQ-006 SHALL have port REG_WE  in  1  register write strobe, one cycle per write.
REQ-007 SHALL have port REG_DI  in  8  register write data.
REQ-008 SHALL have port REG_DO  out  8  combinational read data for REG_SEL.
REQ-009 SHALL have port HBLANK  in  1  PPU mode-0 indicator.
REQ-010 SHALL have port LCD_ON  in  1  LCD enable.
REQ-011 SHALL have port CPU_HOLD  out  1  CPU stall request while a block is in flight.
REQ-012 SHALL have port SRC_STB  out  1  source read request; also serves as CYC.
REQ-013 SHALL have port SRC_ADDR  out  SrcAddrWidth  source byte address.
REQ-014 SHALL have port SRC_DAT  in  8  source read data, valid with SRC_ACK.
REQ-015 SHALL have port SRC_ACK  in  1  source completion.
REQ-016 SHALL have port SRC_STALL  in  1  source not accepting a request.
REQ-017 SHALL have port VRAM_STB  out  1  VRAM write request; also serves as CYC; port is write-only.
REQ-018 SHALL have port VRAM_ADDR  out  VramAddrWidth  VRAM byte address.
REQ-019 SHALL have port VRAM_DAT  out  8  VRAM write data.
REQ-020 SHALL have port VRAM_ACK  in  1  VRAM completion.
REQ-021 SHALL have port VRAM_STALL  in  1  VRAM not accepting a request.

Function
REQ-022 SHALL form the source address as {FF51, FF52[7:4], 4'h0}, with FF52[3:0] ignored.
REQ-023 SHALL form the destination address as {FF53[4:0], FF54[7:4], 4'h0}, with FF53[7:5] and FF54[3:0] ignored.
REQ-024 SHALL ignore writes to FF51..FF54 while a transfer is active; reads of FF51..FF54 SHALL return 8'hFF.
REQ-025 SHALL, on an FF55 write while idle: bit7=0 start GDMA; bit7=1 arm HDMA; remaining = bits[6:0], giving length (remaining+1)*16 bytes.
REQ-026 SHALL use states IDLE, ARMED, READ, WRITE and BLOCK_END; GDMA goes IDLE->READ on the cycle after the write, and HDMA goes IDLE->ARMED.
REQ-027 SHALL move ARMED->READ only on an HBLANK rising edge while LCD_ON=1, one block per edge; edges arriving mid-block SHALL be dropped, not queued.
REQ-028 SHALL, in READ, assert SRC_STB and hold SRC_ADDR stable until a cycle with SRC_STB & !SRC_STALL, then deassert SRC_STB and wait for SRC_ACK.
REQ-029 SHALL latch SRC_DAT on SRC_ACK, then move to WRITE, which drives VRAM_STB, VRAM_ADDR and VRAM_DAT under the same stall/ack rule.
REQ-030 SHALL keep at most one outstanding transaction per port and never assert SRC_STB and VRAM_STB in the same cycle.
REQ-031 SHALL, on VRAM_ACK, increment source (wrap FFFF->0000) and destination (wrap 1FFF->0000) and increment a 4-bit byte counter; on wrap to 0 it goes to BLOCK_END, otherwise to READ.
REQ-032 SHALL, in BLOCK_END with remaining=0, go to IDLE and make FF55 read 8'hFF; otherwise decrement remaining and go to READ (GDMA) or ARMED (HDMA).
REQ-033 SHALL return FF55 reads as {1'b0, remaining} while active and as {1'b1, remaining} after a cancel.
REQ-034 SHALL treat an FF55 write with bit7=0 during HDMA as a cancel: immediate if ARMED, otherwise taking effect at BLOCK_END (the block completes); a bit7=1 write SHALL reload remaining.
REQ-035 SHALL, when an FF55 write coincides with BLOCK_END, apply the block-end decrement first and then the write.
REQ-036 SHALL assert CPU_HOLD from entry to READ until the cycle after the block's final VRAM_ACK (the whole transfer for GDMA), and deassert it in ARMED and IDLE.

Reset
REQ-037 SHALL, while RST is high, force state IDLE, SRC_STB=0, VRAM_STB=0, CPU_HOLD=0, all address/data outputs 0, register file 0, and FF55 reads 8'hFF, regardless of any transaction in flight.

Verification
REQ-038 SHALL pass: FF51=C0, FF52=00, FF53=80, FF54=00, FF55=01 -> 32 reads C000..C01F, 32 VRAM writes 0000..001F with matching data, CPU_HOLD continuous, FF55 then reads FF.
REQ-039 SHALL pass: FF55=82 with LCD_ON=1 and three HBLANK rising edges -> exactly 16 bytes per edge, FF55 reading 01, 00, then FF; no transfer between edges.
REQ-040 SHALL pass: FF55=82, one block done, then FF55=00 -> no transfer on further HBLANK edges, FF55 reads 81.
REQ-041 SHALL pass: SRC_STALL held high for 3 cycles during READ -> SRC_STB and SRC_ADDR stable throughout, no byte lost or duplicated; same check for VRAM_STALL.
REQ-042 SHALL pass: RST pulsed mid-GDMA (byte 5) -> all strobes and CPU_HOLD low immediately, and FF55 reads FF after release.
REQ-043 SHALL pass: FF52=3F, FF54=FF, FF53=E1 -> first SRC_ADDR low byte is 30 and first VRAM_ADDR is 01F0.
